// File: rtl/tcon_demux.sv
// Steers a tagged word stream into two independent DEPTH-entry FIFO channels:
// words tagged sel=1 go to channel A, words tagged sel=0 go to channel S.
module tcon_demux #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic             clk_pad,
    input  logic             rst_pad,
    input  logic             in_valid_pad,
    output logic             in_ready_pad,
    input  logic [WIDTH-1:0] in_data_pad,
    input  logic             in_sel_pad,
    output logic             a_valid_pad,
    input  logic             a_ready_pad,
    output logic [WIDTH-1:0] a_data_pad,
    output logic [LW-1:0]    a_level_pad,
    output logic             s_valid_pad,
    input  logic             s_ready_pad,
    output logic [WIDTH-1:0] s_data_pad,
    output logic [LW-1:0]    s_level_pad
);

    localparam int PW = $clog2(DEPTH);
    localparam int CH_S = 0;
    localparam int CH_A = 1;

    logic [WIDTH-1:0] mem    [2][DEPTH];
    logic [PW-1:0]    wr_ptr [2];
    logic [PW-1:0]    rd_ptr [2];
    logic [LW-1:0]    level  [2];

    logic [1:0] full;
    logic [1:0] empty;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] cons_ready;

    // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        cons_ready = {a_ready_pad, s_ready_pad};
        full       = '0;
        empty      = '0;
        pop        = '0;
        for (int c = 0; c < 2; c++) begin
            full[c]  = (level[c] == LW'(DEPTH));
            empty[c] = (level[c] == '0);
            pop[c]   = ~empty[c] & cons_ready[c];
        end
        // Readiness looks only at the selected channel's registered level; a same-cycle pop never frees a slot.
        in_ready_pad = in_sel_pad ? ~full[CH_A] : ~full[CH_S];
        push[CH_A]   = in_valid_pad & in_ready_pad & in_sel_pad;
        push[CH_S]   = in_valid_pad & in_ready_pad & ~in_sel_pad;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every read in this block sees pre-edge values.
    always_ff @(posedge clk_pad) begin
        if (rst_pad) begin
            for (int c = 0; c < 2; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                level[c]  <= '0;
                // NOTE: storage is cleared too, because the head word is visible on the data outputs and must read 0 after reset.
                for (int i = 0; i < DEPTH; i++) begin
                    mem[c][i] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (push[c]) begin
                    mem[c][wr_ptr[c]] <= in_data_pad;
                    wr_ptr[c]         <= wr_ptr[c] + 1'b1;
                end
                if (pop[c]) begin
                    rd_ptr[c] <= rd_ptr[c] + 1'b1;
                end
                case ({push[c], pop[c]})
                    2'b10:   level[c] <= level[c] + LW'(1);
                    2'b01:   level[c] <= level[c] - LW'(1);
                    default: level[c] <= level[c];
                endcase
            end
        end
    end

    assign a_valid_pad = ~empty[CH_A];
    assign a_data_pad  = mem[CH_A][rd_ptr[CH_A]];
    assign a_level_pad = level[CH_A];
    assign s_valid_pad = ~empty[CH_S];
    assign s_data_pad  = mem[CH_S][rd_ptr[CH_S]];
    assign s_level_pad = level[CH_S];

endmodule

// File: tb/tb_tcon_demux.sv
// Directed self-checking bench for tcon_demux with WIDTH=8, DEPTH=2.
module tb_tcon_demux;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int LW    = 2;

    logic             clk_pad;
    logic             rst_pad;
    logic             in_valid_pad;
    logic             in_ready_pad;
    logic [WIDTH-1:0] in_data_pad;
    logic             in_sel_pad;
    logic             a_valid_pad;
    logic             a_ready_pad;
    logic [WIDTH-1:0] a_data_pad;
    logic [LW-1:0]    a_level_pad;
    logic             s_valid_pad;
    logic             s_ready_pad;
    logic [WIDTH-1:0] s_data_pad;
    logic [LW-1:0]    s_level_pad;

    int vectors     = 0;
    int miscompares = 0;

    tcon_demux #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_pad      (clk_pad),
        .rst_pad      (rst_pad),
        .in_valid_pad (in_valid_pad),
        .in_ready_pad (in_ready_pad),
        .in_data_pad  (in_data_pad),
        .in_sel_pad   (in_sel_pad),
        .a_valid_pad  (a_valid_pad),
        .a_ready_pad  (a_ready_pad),
        .a_data_pad   (a_data_pad),
        .a_level_pad  (a_level_pad),
        .s_valid_pad  (s_valid_pad),
        .s_ready_pad  (s_ready_pad),
        .s_data_pad   (s_data_pad),
        .s_level_pad  (s_level_pad)
    );

    initial clk_pad = 1'b0;
    always #5 clk_pad = ~clk_pad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit before sampling or driving.
    task automatic step();
        @(posedge clk_pad);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " a_valid"}, a_valid_pad, 0);
        check({tag, " s_valid"}, s_valid_pad, 0);
        check({tag, " a_data"},  a_data_pad,  0);
        check({tag, " s_data"},  s_data_pad,  0);
        check({tag, " a_level"}, a_level_pad, 0);
        check({tag, " s_level"}, s_level_pad, 0);
    endtask

    initial begin
        rst_pad      = 1'b1;
        in_valid_pad = 1'b1;
        in_data_pad  = WIDTH'($urandom);
        in_sel_pad   = 1'($urandom_range(0, 1));
        a_ready_pad  = 1'($urandom_range(0, 1));
        s_ready_pad  = 1'($urandom_range(0, 1));

        // Reset held two cycles with a push offered every cycle
        for (int i = 0; i < 2; i++) begin
            step();
            check_idle("reset");
            in_sel_pad = 1'b0;
            #1 check("reset in_ready sel0", in_ready_pad, 1);
            in_sel_pad = 1'b1;
            #1 check("reset in_ready sel1", in_ready_pad, 1);
            in_data_pad = WIDTH'($urandom);
        end
        rst_pad      = 1'b0;
        in_valid_pad = 1'b0;
        step();
        check_idle("post reset");

        // Steering
        a_ready_pad  = 1'b1;
        s_ready_pad  = 1'b1;
        in_valid_pad = 1'b1;
        in_data_pad  = 8'h5A;
        in_sel_pad   = 1'b1;
        step();
        check("steer a_valid", a_valid_pad, 1);
        check("steer a_data",  a_data_pad,  8'h5A);
        check("steer s_valid", s_valid_pad, 0);
        in_data_pad = 8'hA5;
        in_sel_pad  = 1'b0;
        step();
        check("steer s_valid",   s_valid_pad, 1);
        check("steer s_data",    s_data_pad,  8'hA5);
        check("steer a_drained", a_valid_pad, 0);
        check("steer a_level",   a_level_pad, 0);
        in_valid_pad = 1'b0;
        step();
        check("steer s_drained", s_valid_pad, 0);

        // A backpressure
        a_ready_pad  = 1'b0;
        s_ready_pad  = 1'b0;
        in_valid_pad = 1'b1;
        in_sel_pad   = 1'b1;
        in_data_pad  = 8'h01;
        step();
        in_data_pad = 8'h02;
        step();
        check("bp a_level", a_level_pad, 2);
        in_sel_pad = 1'b1;
        #1 check("bp in_ready sel1", in_ready_pad, 0);
        in_sel_pad = 1'b0;
        #1 check("bp in_ready sel0", in_ready_pad, 1);
        in_data_pad = 8'h03;
        step();
        check("bp s_level",  s_level_pad, 1);
        check("bp s_data",   s_data_pad,  8'h03);
        check("bp a_level2", a_level_pad, 2);
        check("bp a_data",   a_data_pad,  8'h01);
        in_valid_pad = 1'b0;
        a_ready_pad  = 1'b1;
        step();
        check("bp a_second", a_data_pad,  8'h02);
        check("bp a_lvl1",   a_level_pad, 1);
        step();
        check("bp a_empty",  a_valid_pad, 0);
        s_ready_pad = 1'b1;
        step();
        check("bp s_empty",  s_level_pad, 0);

        // Full plus pop
        a_ready_pad  = 1'b0;
        in_valid_pad = 1'b1;
        in_sel_pad   = 1'b1;
        in_data_pad  = 8'h11;
        step();
        in_data_pad = 8'h22;
        step();
        check("fp full level", a_level_pad, 2);
        a_ready_pad = 1'b1;
        in_data_pad = 8'h33;
        #1 check("fp in_ready full", in_ready_pad, 0);
        step();
        check("fp level 2to1", a_level_pad, 1);
        check("fp head 22",    a_data_pad,  8'h22);
        check("fp in_ready",   in_ready_pad, 1);
        step();
        check("fp level hold", a_level_pad, 1);
        check("fp head 33",    a_data_pad,  8'h33);
        in_valid_pad = 1'b0;
        step();
        check("fp drained", a_level_pad, 0);

        // Streaming with wrap-around: A takes even indices, S takes odd
        a_ready_pad  = 1'b1;
        s_ready_pad  = 1'b1;
        in_valid_pad = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data_pad = WIDTH'(i);
            in_sel_pad  = (i % 2 == 0);
            step();
            if (i % 2 == 0) begin
                check("stream a_data",  a_data_pad,  i);
                check("stream a_valid", a_valid_pad, 1);
                check("stream a_level", a_level_pad, 1);
                check("stream s_level", s_level_pad, 0);
            end else begin
                check("stream s_data",  s_data_pad,  i);
                check("stream s_valid", s_valid_pad, 1);
                check("stream s_level", s_level_pad, 1);
                check("stream a_level", a_level_pad, 0);
            end
        end
        in_valid_pad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stream tail a_level", a_level_pad, 0);
            check("stream tail s_level", s_level_pad, 0);
        end

        // Reset mid-stream with A holding two words
        a_ready_pad  = 1'b0;
        in_valid_pad = 1'b1;
        in_sel_pad   = 1'b1;
        in_data_pad  = 8'h44;
        step();
        in_data_pad = 8'h55;
        step();
        check("mid full", a_level_pad, 2);
        rst_pad     = 1'b1;
        a_ready_pad = 1'b1;
        in_data_pad = 8'h66;
        step();
        check("mid a_valid", a_valid_pad, 0);
        check("mid a_level", a_level_pad, 0);
        check("mid a_data",  a_data_pad,  0);
        rst_pad      = 1'b0;
        in_valid_pad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid no stale", a_valid_pad, 0);
        end
        in_valid_pad = 1'b1;
        in_data_pad  = 8'h77;
        step();
        check("mid recover data",  a_data_pad,  8'h77);
        check("mid recover level", a_level_pad, 1);
        in_valid_pad = 1'b0;
        step();
        check("mid recover drain", a_valid_pad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tcon_demux.md
# tcon_demux

Sequential 1-to-2 byte steering block: the inverse of the `tcon` two-bus output multiplexer. A single input stream of `WIDTH`-bit words, each tagged with a select bit, is routed into one of two buffered output channels. Channel A takes words tagged `in_sel_pad`=1, the same polarity for which the `tcon` mux passes its a..h bus. Channel S takes words tagged 0, matching the s..z bus. Each channel has an independent valid/ready interface and a `DEPTH`-entry FIFO, so a stalled consumer on one channel never blocks traffic routed to the other.

## Interface

Parameters:

- `WIDTH`, default 8: data word width; 8 matches the `tcon` bus width.
- `DEPTH`, default 2: per-channel FIFO depth; a power of two, ≥ 2.
- `LW`, default clog2(`DEPTH`)+1: width of the level outputs. Derived; not overridable.

Ports:

- `clk_pad` input 1: the single clock; all state changes on the rising edge.
- `rst_pad` input 1: synchronous, active-high reset.
- `in_valid_pad` input 1: input word present.
- `in_ready_pad` output 1: block can accept the input word.
- `in_data_pad` input `WIDTH`: input word.
- `in_sel_pad` input 1: route select; 1 selects channel A, 0 selects channel S.
- `a_valid_pad` output 1: channel A head word valid.
- `a_ready_pad` input 1: channel A consumer accepts the head word.
- `a_data_pad` output `WIDTH`: channel A head word.
- `a_level_pad` output `LW`: channel A occupancy, 0..`DEPTH`.
- `s_valid_pad` output 1: channel S head word valid.
- `s_ready_pad` input 1: channel S consumer accepts the head word.
- `s_data_pad` output `WIDTH`: channel S head word.
- `s_level_pad` output `LW`: channel S occupancy, 0..`DEPTH`.

## Operation

- **Channels:** two identical circular FIFOs, A and S. Each has `DEPTH` storage words, a write pointer and a read pointer (clog2(`DEPTH`) bits each, wrapping modulo `DEPTH`), and a level counter of `LW` bits.
- **Full / empty:** full = level==`DEPTH`; empty = level==0.
- **in_ready_pad:** equals ~full of the selected channel: `in_sel_pad` ? ~fullA : ~fullS. It is combinational from `in_sel_pad` and registered state only. It never depends on `a_ready_pad` or `s_ready_pad`.
- **Push:** a push occurs when `in_valid_pad` & `in_ready_pad`. The word is written at the selected channel's write pointer, which then increments. The unselected channel is untouched.
- **Output side:** `x_valid_pad` = ~empty and `x_data_pad` = storage[read pointer], both driven from registers.
- **Pop:** a pop occurs when `x_valid_pad` & `x_ready_pad`; the read pointer increments.
- **Level update:** +1 on push only, −1 on pop only, unchanged on simultaneous push and pop to the same channel.
- **Independent channels:** a push to one channel and a pop from the other in the same cycle are independent.
- **Full channel with pop:** when a channel is full and its consumer pops in the same cycle, `in_ready_pad` for that channel stays 0 that cycle. There is no pass-through; the slot frees on the next cycle.
- **Empty channel:** no bypass. A word written to an empty channel appears on its outputs the cycle after the push.
- **Ready without valid:** `x_ready_pad` asserted while `x_valid_pad`=0 has no effect.
- **Sel change under backpressure:** `in_sel_pad` may change while `in_valid_pad` is held. Readiness follows the current select value.
- **Reset:** pointers, levels and all storage words go to 0. During and after reset: `in_ready_pad`=1 for both select values, `a_valid_pad`=`s_valid_pad`=0, `a_data_pad`=`s_data_pad`=0, `a_level_pad`=`s_level_pad`=0.
- **Reset mid-operation:** all buffered words are discarded. Handshakes in the reset cycle are ignored: no push, no pop.

## Timing

- **Latency:** 1 cycle. A word pushed at edge k is visible on `x_valid_pad`/`x_data_pad` after edge k, and can be popped at edge k+1.
- **Throughput:** 1 word per cycle per channel in steady state, with one input word per cycle total.
- **Sustained throughput with DEPTH≥2:** achieved when the consumer keeps its ready high.
- **Output stability:** `x_data_pad` and `x_valid_pad` stay stable while `x_valid_pad`=1 and `x_ready_pad`=0.
- **Combinational paths:** the only input-to-output path is `in_sel_pad` → `in_ready_pad`.

## Test plan

- **Reset:** assert `rst_pad` 2 cycles with random inputs → all valids 0, data 0, levels 0, `in_ready_pad`=1. Pushes offered during reset are not stored.
- **Steering:** push 0x5A sel=1, then 0xA5 sel=0, with both readies high. Expected:
  - `a_data_pad`=0x5A valid one cycle after its push;
  - `s_data_pad`=0xA5 one cycle after its push;
  - neither word appears on the other channel.
- **A backpressure:** `a_ready_pad`=0; push 0x01, 0x02 sel=1 (DEPTH=2). Expected:
  - `a_level_pad`=2;
  - `in_ready_pad`=0 when sel=1, 1 when sel=0;
  - push 0x03 sel=0 accepted onto S.
  - Then raise `a_ready_pad`: A emits 0x01, 0x02 in order.
- **Full plus pop:** channel A full, `a_ready_pad`=1, `in_valid_pad`=1, sel=1. Expected:
  - first cycle: pop only, `in_ready_pad`=0, level 2→1;
  - next cycle: push accepted and pop, level stays 1.
- **Streaming and wrap-around:** stream 0x00..0x0F alternating sel, readies held high for 20 cycles. Expected:
  - A outputs the even-indexed words and S the odd-indexed words, each in order;
  - pointers wrap with no loss;
  - levels never exceed 1.
- **Reset mid-stream:** A holds 2 words; assert `rst_pad` 1 cycle with `a_ready_pad`=1 → `a_valid_pad`=0 and `a_level_pad`=0 next cycle; no stale word is ever emitted afterwards.
